npc_pc_unit: RTL and testbench

Parametrised successor to the combinational next-PC selector: owns the architectural PC register and computes the next fetch address each cycle. Supports sequential, branch, absolute jump, jump-register and return redirection, with a stall input. An internal return-address stack (RAS) of configurable depth is pushed by jump-and-link and popped by return. Sits at the front of the fetch stage, feeding instruction memory, and receives decode and ALU results (jump, branch, zero, imm, rs_data).

---
 rtl/npc_pc_unit.sv | 157 +++++++++++++++
 tb/tb_npc_pc_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/npc_pc_unit.sv
// -----------------------------------------------------------------------------
// npc_pc_unit
//   Front-of-fetch program counter unit. Holds the architectural PC and
//   selects the next fetch address every cycle from sequential, branch,
//   absolute jump, jump-register and return sources. A small circular
//   return-address stack (RAS) is pushed by jump-and-link and popped by return.
//
// Ports
//   clk, rst       : clock (rising edge) and synchronous active-high reset
//   stall          : hold PC and freeze the RAS
//   jump, link     : absolute jump; with link also push pc+4 onto the RAS
//   jr, ret        : jump to rs_data; with ret pop the RAS instead
//   branch, zero   : conditional branch, taken when both are set
//   instr_index    : 26-bit jump target field
//   imm            : signed branch word offset
//   rs_data        : register jump target
//   pc             : current fetch address (registered)
//   pc_plus4       : pc + 4 (combinational, link write-back value)
//   ras_count      : number of valid RAS entries
//   ras_underflow  : one-cycle pulse, return issued with an empty RAS
//   addr_err       : one-cycle pulse, jump-register target was misaligned
// -----------------------------------------------------------------------------
module npc_pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000),
    parameter int                RAS_DEPTH = 4,
    parameter int                IMM_W     = 16,
    localparam int               CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump,
    input  logic              link,
    input  logic              jr,
    input  logic              ret,
    input  logic              branch,
    input  logic              zero,
    input  logic [25:0]       instr_index,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_underflow,
    output logic              addr_err
);

    // A depth-1 stack still needs a one-bit pointer to keep the code uniform.
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  top_reg, top_next;
    logic              underflow_reg, underflow_next;
    logic              addr_err_reg, addr_err_next;

    logic [PTR_W-1:0]  top_inc, top_dec;
    logic              push_en;

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] jr_target;

    // The return target is needed in the same cycle the return is decoded,
    // so the stack is read asynchronously from a small register array.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    assign pc_plus4 = pc_reg + ADDR_W'(4);

    // Absolute jump keeps the current 256 MB region (upper PC bits).
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign jump_target = {pc_reg[ADDR_W-1:28], instr_index, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {instr_index, 2'b00};
        end
    endgenerate

    // Word offset, sign-extended to the address width; wraps modulo 2^ADDR_W.
    assign imm_ext       = {{(ADDR_W - IMM_W){imm[IMM_W-1]}}, imm};
    assign branch_target = pc_plus4 + (imm_ext << 2);

    // Circular pointer arithmetic that also works for non-power-of-two depths.
    assign top_inc = (top_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_reg + PTR_W'(1);
    assign top_dec = (top_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : top_reg - PTR_W'(1);

    always_comb begin
        pc_next        = pc_reg;
        count_next     = count_reg;
        top_next       = top_reg;
        underflow_next = 1'b0;
        addr_err_next  = 1'b0;
        push_en        = 1'b0;
        jr_target      = rs_data;

        if (!stall) begin
            if (jr) begin
                if (ret && (count_reg != '0)) begin
                    jr_target  = ras_mem[top_reg];
                    top_next   = top_dec;
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    jr_target      = rs_data;
                    underflow_next = ret;
                end
                // Misaligned register targets are forced to a word boundary.
                pc_next       = {jr_target[ADDR_W-1:2], 2'b00};
                addr_err_next = |jr_target[1:0];
            end else if (jump) begin
                pc_next = jump_target;
                if (link) begin
                    push_en  = 1'b1;
                    top_next = top_inc;
                    // When full the push overwrites the oldest entry, count saturates.
                    if (count_reg != CNT_W'(RAS_DEPTH)) begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end else if (branch && zero) begin
                pc_next = branch_target;
            end else begin
                pc_next = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            count_reg     <= '0;
            top_reg       <= '0;
            underflow_reg <= 1'b0;
            addr_err_reg  <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            count_reg     <= count_next;
            top_reg       <= top_next;
            underflow_reg <= underflow_next;
            addr_err_reg  <= addr_err_next;
        end
    end

    // Stack contents need no reset; only the pointer and count matter.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            ras_mem[top_inc] <= pc_plus4;
        end
    end

    assign pc            = pc_reg;
    assign ras_count     = count_reg;
    assign ras_underflow = underflow_reg;
    assign addr_err      = addr_err_reg;

endmodule

// File: tb/tb_npc_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_npc_pc_unit
//   Directed self-checking bench for npc_pc_unit with default parameters.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_npc_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, jump, link, jr, ret, branch, zero;
    logic [25:0] instr_index;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] pc, pc_plus4;
    logic [2:0]  ras_count;
    logic        ras_underflow, addr_err;

    int checks = 0;
    int errors = 0;

    npc_pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .jump         (jump),
        .link         (link),
        .jr           (jr),
        .ret          (ret),
        .branch       (branch),
        .zero         (zero),
        .instr_index  (instr_index),
        .imm          (imm),
        .rs_data      (rs_data),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .ras_count    (ras_count),
        .ras_underflow(ras_underflow),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst = 0; stall = 0; jump = 0; link = 0; jr = 0; ret = 0;
        branch = 0; zero = 0; instr_index = '0; imm = '0; rs_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One line per transaction: pc, count and both pulses.
    task automatic chk_state(input string tag, input logic [31:0] e_pc, input int e_cnt,
                             input logic e_uf, input logic e_ae);
        $display("%-14s pc=%h cnt=%0d uf=%b ae=%b", tag, pc, ras_count, ras_underflow, addr_err);
        chk({tag, ".pc"},  pc, e_pc);
        chk({tag, ".cnt"}, 32'(ras_count), 32'(e_cnt));
        chk({tag, ".uf"},  32'(ras_underflow), 32'(e_uf));
        chk({tag, ".ae"},  32'(addr_err), 32'(e_ae));
    endtask

    initial begin
        idle_inputs();
        // Reset, then sequential fetch.
        rst = 1; step(); rst = 0;
        chk_state("reset", 32'h3000, 0, 0, 0);
        chk("reset.pc4", pc_plus4, 32'h3004);
        step(); chk_state("seq1", 32'h3004, 0, 0, 0);
        step(); chk_state("seq2", 32'h3008, 0, 0, 0);
        ret = 1;                                   // ret without jr is ignored
        step(); chk_state("ret_nojr", 32'h300C, 0, 0, 0);
        ret = 0;
        chk("seq3.pc4", pc_plus4, 32'h3010);
        step(); chk_state("seq4", 32'h3010, 0, 0, 0);

        // Branch taken backwards: 0x3010 + 4 - 8.
        branch = 1; zero = 1; imm = 16'hFFFE;
        step(); chk_state("br_taken", 32'h300C, 0, 0, 0);
        idle_inputs();
        step(); chk_state("seq5", 32'h3010, 0, 0, 0);
        branch = 1; zero = 0; imm = 16'hFFFE;
        step(); chk_state("br_not", 32'h3014, 0, 0, 0);
        idle_inputs();
        step(); step(); step(); chk_state("seq6", 32'h3020, 0, 0, 0);

        // Jump-and-link, then stall with a pending return.
        jump = 1; link = 1; instr_index = 26'h0000C40;
        step(); chk_state("jal", 32'h3100, 1, 0, 0);
        idle_inputs();
        stall = 1; jr = 1; ret = 1; rs_data = 32'hDEAD_0000;
        step(); chk_state("stall1", 32'h3100, 1, 0, 0);
        step(); chk_state("stall2", 32'h3100, 1, 0, 0);
        chk("stall.pc4", pc_plus4, 32'h3104);
        stall = 0;
        step(); chk_state("ret_hit", 32'h3024, 0, 0, 0);
        idle_inputs();

        // Five pushes into a four-entry stack: A1 (0x3028) is overwritten.
        jump = 1; link = 1;
        instr_index = 26'h0001400; step(); chk_state("push1", 32'h5000, 1, 0, 0);
        instr_index = 26'h0001440; step(); chk_state("push2", 32'h5100, 2, 0, 0);
        instr_index = 26'h0001480; step(); chk_state("push3", 32'h5200, 3, 0, 0);
        instr_index = 26'h00014C0; step(); chk_state("push4", 32'h5300, 4, 0, 0);
        instr_index = 26'h0001500; step(); chk_state("push5", 32'h5400, 4, 0, 0);
        idle_inputs();
        jr = 1; ret = 1; rs_data = 32'h4000;
        step(); chk_state("pop1", 32'h5304, 3, 0, 0);
        step(); chk_state("pop2", 32'h5204, 2, 0, 0);
        step(); chk_state("pop3", 32'h5104, 1, 0, 0);
        step(); chk_state("pop4", 32'h5004, 0, 0, 0);
        step(); chk_state("pop5_uf", 32'h4000, 0, 1, 0);
        idle_inputs();
        step(); chk_state("uf_clear", 32'h4004, 0, 0, 0);

        // Misaligned register jump.
        jr = 1; rs_data = 32'h3207;
        step(); chk_state("jr_misal", 32'h3204, 0, 0, 1);
        idle_inputs();
        step(); chk_state("ae_clear", 32'h3208, 0, 0, 0);

        // jr beats jump-and-link; nothing is pushed.
        jr = 1; jump = 1; link = 1; rs_data = 32'h3300; instr_index = 26'h0000100;
        step(); chk_state("jr_vs_jal", 32'h3300, 0, 0, 0);
        idle_inputs();

        // Jump keeps the upper PC nibble.
        jr = 1; rs_data = 32'hFFFF_FFF8;
        step(); chk_state("jr_high", 32'hFFFF_FFF8, 0, 0, 0);
        idle_inputs();
        jump = 1; instr_index = 26'h0000010;
        step(); chk_state("j_region", 32'hF000_0040, 0, 0, 0);
        idle_inputs();

        // Sequential wrap at the top of the address space.
        jr = 1; rs_data = 32'hFFFF_FFFC;
        step(); chk_state("jr_top", 32'hFFFF_FFFC, 0, 0, 0);
        idle_inputs();
        chk("top.pc4", pc_plus4, 32'h0000_0000);
        step(); chk_state("wrap", 32'h0000_0000, 0, 0, 0);

        // Reset wins over a stalled jump-and-link with a non-empty stack.
        jump = 1; link = 1; instr_index = 26'h0000010;
        step(); chk_state("jal_pre_rst", 32'h0000_0040, 1, 0, 0);
        rst = 1; stall = 1;
        step(); chk_state("rst_mid", 32'h3000, 0, 0, 0);
        idle_inputs();
        step(); chk_state("post_rst", 32'h3004, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
